// File: rtl/board_pkg.sv
// Shared board constants, player encoding and drop FSM state type.
package board_pkg;
  localparam int COLS = 16;
  localparam int ROWS = 16;

  localparam logic PLAYER_GRN = 1'b0;
  localparam logic PLAYER_RED = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INJECT,
    S_FALL
  } drop_state_e;
endpackage

// File: rtl/drop_controller_if.sv
// Button/column-status inputs and injection/cursor outputs of the drop controller.
interface drop_controller_if #(
  parameter int COLS = board_pkg::COLS
);
  logic                    enable;
  logic                    left;
  logic                    right;
  logic                    drop;
  logic [COLS-1:0]         colFull;
  logic [COLS-1:0]         topG;
  logic [COLS-1:0]         topR;
  logic [$clog2(COLS)-1:0] cursor;
  logic                    player;
  logic                    busy;

  modport master (
    output enable, left, right, drop, colFull,
    input  topG, topR, cursor, player, busy
  );

  modport slave (
    input  enable, left, right, drop, colFull,
    output topG, topR, cursor, player, busy
  );
endinterface

// File: rtl/btn_edge.sv
// One-bit rising-edge detector for an already-synchronised button level.
module btn_edge (
  input  logic clk,
  input  logic RST,
  input  logic i_btn,
  output logic o_press
);
  logic r_btn_q;

  always_ff @(posedge clk) begin
    if (RST) r_btn_q <= 1'b0;
    else     r_btn_q <= i_btn;
  end

  assign o_press = i_btn & ~r_btn_q;
endmodule

// File: rtl/drop_controller.sv
// Cursor movement, turn order and one-cycle piece injection into row 0,
// followed by a fixed settle wait while the piece falls.
module drop_controller
  import board_pkg::*;
#(
  parameter int COLS          = board_pkg::COLS,
  parameter int SETTLE_CYCLES = 17,
  parameter int CURSOR_RESET  = 7
) (
  input  logic             clk,
  input  logic             RST,
  drop_controller_if.slave bus
);
  localparam int CW = $clog2(COLS);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] CNT_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CUR_MAX  = CW'(COLS - 1);

  drop_state_e     r_state, w_state_nxt;
  logic [CW-1:0]   r_cursor, w_cursor_nxt;
  logic [SW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_player, w_player_nxt;
  logic [COLS-1:0] r_topG, r_topR;
  logic            r_busy;
  logic            w_left_p, w_right_p, w_drop_p, w_go;

  // Edge registers run in every state so a button held through a fall stays quiet.
  btn_edge u_left  (.clk(clk), .RST(RST), .i_btn(bus.left),  .o_press(w_left_p));
  btn_edge u_right (.clk(clk), .RST(RST), .i_btn(bus.right), .o_press(w_right_p));
  btn_edge u_drop  (.clk(clk), .RST(RST), .i_btn(bus.drop),  .o_press(w_drop_p));

  assign w_go = w_drop_p & ~bus.colFull[r_cursor];

  always_comb begin
    w_state_nxt  = r_state;
    w_cursor_nxt = r_cursor;
    w_cnt_nxt    = r_cnt;
    w_player_nxt = r_player;
    unique case (r_state)
      S_IDLE: begin
        if (bus.enable) begin
          if (w_go) begin
            w_state_nxt = S_INJECT;
          end else if (w_left_p && !w_right_p) begin
            if (r_cursor != '0) w_cursor_nxt = r_cursor - 1'b1;
          end else if (w_right_p && !w_left_p) begin
            if (r_cursor != CUR_MAX) w_cursor_nxt = r_cursor + 1'b1;
          end
        end
      end
      S_INJECT: begin
        w_state_nxt = S_FALL;
        w_cnt_nxt   = '0;
      end
      S_FALL: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt  = S_IDLE;
          w_player_nxt = ~r_player;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cursor <= CW'(CURSOR_RESET);
      r_cnt    <= '0;
      r_player <= PLAYER_GRN;
      r_topG   <= '0;
      r_topR   <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cursor <= w_cursor_nxt;
      r_cnt    <= w_cnt_nxt;
      r_player <= w_player_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      // Registered so the pulse coincides exactly with the S_INJECT cycle.
      r_topG   <= '0;
      r_topR   <= '0;
      if (w_state_nxt == S_INJECT) begin
        r_topG[w_cursor_nxt] <= ~r_player;
        r_topR[w_cursor_nxt] <= r_player;
      end
    end
  end

  assign bus.topG   = r_topG;
  assign bus.topR   = r_topR;
  assign bus.cursor = r_cursor;
  assign bus.player = r_player;
  assign bus.busy   = r_busy;
endmodule

// File: tb/tb_drop_controller.sv
// Scoreboard bench for drop_controller: stimulus queues expected cursor,
// injection and turn-end events; a negedge monitor pops and compares them.
module tb_drop_controller;
  import board_pkg::*;

  typedef enum int {EV_CUR, EV_INJ, EV_DONE} ev_e;
  typedef struct {
    ev_e         kind;
    logic [15:0] a;
    logic [15:0] b;
    int          len;
  } exp_t;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  drop_controller_if #(.COLS(16)) bus ();

  drop_controller #(
    .COLS(16),
    .SETTLE_CYCLES(17),
    .CURSOR_RESET(7)
  ) dut (
    .clk(clk),
    .RST(RST),
    .bus(bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  bit   mon_on = 1'b0;

  task automatic push(input ev_e k, input logic [15:0] a, input logic [15:0] b, input int len);
    exp_t e;
    e.kind = k; e.a = a; e.b = b; e.len = len;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic got_event(input ev_e k, input logic [15:0] a, input logic [15:0] b, input int len);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind %0d got a=%h b=%h len=%0d want none", k, a, b, len);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.a !== a || e.b !== b || (e.len != 0 && e.len != len)) begin
        errors++;
        $display("FAIL event got kind %0d a=%h b=%h len=%0d want kind %0d a=%h b=%h len=%0d",
                 k, a, b, len, e.kind, e.a, e.b, e.len);
      end
    end
  endtask

  // Monitor
  initial begin
    logic [3:0] prev_cur;
    logic       prev_busy;
    int         busy_len;
    bit         primed;
    primed = 1'b0;
    busy_len = 0;
    prev_cur = '0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (!primed) begin
          primed = 1'b1;
        end else begin
          checks++;
          if ((bus.topG & bus.topR) != '0) begin
            errors++;
            $display("FAIL overlap got topG=%h topR=%h want disjoint", bus.topG, bus.topR);
          end
          if (bus.cursor != prev_cur) got_event(EV_CUR, {12'b0, bus.cursor}, 16'h0, 0);
          if ((bus.topG | bus.topR) != '0) got_event(EV_INJ, bus.topG, bus.topR, 0);
          if (prev_busy && !bus.busy) begin
            got_event(EV_DONE, {15'b0, bus.player}, 16'h0, busy_len);
            busy_len = 0;
          end
        end
        if (bus.busy) busy_len++;
        prev_cur  = bus.cursor;
        prev_busy = bus.busy;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic l, input logic r, input logic d);
    bus.left = l; bus.right = r; bus.drop = d;
    step();
    bus.left = 1'b0; bus.right = 1'b0; bus.drop = 1'b0;
    step();
  endtask

  initial begin
    int guard;
    RST = 1'b1;
    bus.enable = 1'b1;
    bus.left = 1'b0; bus.right = 1'b0; bus.drop = 1'b0;
    bus.colFull = 16'h0;
    step();
    RST = 1'b0;
    chk("rst_cursor", {12'b0, bus.cursor}, 16'd7);
    chk("rst_player", {15'b0, bus.player}, 16'd0);
    chk("rst_topG", bus.topG, 16'h0);
    chk("rst_topR", bus.topR, 16'h0);
    chk("rst_busy", {15'b0, bus.busy}, 16'd0);
    mon_on = 1'b1;
    step();

    // 8 lefts from 7: 6..0 then saturate
    for (int i = 0; i < 8; i++) begin
      if (i < 7) push(EV_CUR, 16'(6 - i), 16'h0, 0);
      press(1'b1, 1'b0, 1'b0);
    end
    chk("sat_low", {12'b0, bus.cursor}, 16'd0);
    // 20 rights from 0: 1..15 then saturate
    for (int i = 0; i < 20; i++) begin
      if (i < 15) push(EV_CUR, 16'(i + 1), 16'h0, 0);
      press(1'b0, 1'b1, 1'b0);
    end
    chk("sat_high", {12'b0, bus.cursor}, 16'd15);
    press(1'b1, 1'b1, 1'b0);
    chk("both_pressed", {12'b0, bus.cursor}, 16'd15);
    // Held left: exactly one decrement
    push(EV_CUR, 16'd14, 16'h0, 0);
    bus.left = 1'b1;
    repeat (5) step();
    bus.left = 1'b0;
    step();
    chk("held_left", {12'b0, bus.cursor}, 16'd14);
    for (int i = 0; i < 11; i++) begin
      push(EV_CUR, 16'(13 - i), 16'h0, 0);
      press(1'b1, 1'b0, 1'b0);
    end
    chk("cursor_at3", {12'b0, bus.cursor}, 16'd3);

    // Green drop
    push(EV_INJ, 16'h0008, 16'h0000, 0);
    push(EV_DONE, 16'd1, 16'h0, 18);
    press(1'b0, 1'b0, 1'b1);
    repeat (22) step();
    chk("green_player", {15'b0, bus.player}, 16'd1);

    // Red drop
    push(EV_INJ, 16'h0000, 16'h0008, 0);
    push(EV_DONE, 16'd0, 16'h0, 18);
    press(1'b0, 1'b0, 1'b1);
    repeat (22) step();
    chk("red_player", {15'b0, bus.player}, 16'd0);

    // Full column
    bus.colFull = 16'h0008;
    press(1'b0, 1'b0, 1'b1);
    chk("full_busy", {15'b0, bus.busy}, 16'd0);
    repeat (20) step();
    chk("full_player", {15'b0, bus.player}, 16'd0);
    bus.colFull = 16'h0;

    // Disabled
    bus.enable = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    repeat (5) step();
    chk("dis_cursor", {12'b0, bus.cursor}, 16'd3);
    chk("dis_player", {15'b0, bus.player}, 16'd0);
    chk("dis_busy", {15'b0, bus.busy}, 16'd0);
    bus.enable = 1'b1;

    // Presses during the fall are ignored
    push(EV_INJ, 16'h0008, 16'h0000, 0);
    push(EV_DONE, 16'd1, 16'h0, 18);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    repeat (20) step();
    chk("lock_cursor", {12'b0, bus.cursor}, 16'd3);
    chk("lock_player", {15'b0, bus.player}, 16'd1);

    // Reset at fall cycle 5
    push(EV_INJ, 16'h0000, 16'h0008, 0);
    press(1'b0, 1'b0, 1'b1);
    repeat (4) step();
    chk("midfall_busy", {15'b0, bus.busy}, 16'd1);
    push(EV_CUR, 16'd7, 16'h0, 0);
    push(EV_DONE, 16'd0, 16'h0, 0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mrst_player", {15'b0, bus.player}, 16'd0);
    chk("mrst_cursor", {12'b0, bus.cursor}, 16'd7);
    chk("mrst_busy", {15'b0, bus.busy}, 16'd0);
    chk("mrst_topG", bus.topG, 16'h0);
    chk("mrst_topR", bus.topR, 16'h0);
    repeat (22) step();

    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      step();
      guard++;
    end
    chk("queue_drained", 16'(q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
